// File: rtl/sprite_scheduler.sv
// Fixed-priority sprite arbiter for a VGA pixel pipeline: inputs are registered, then the grant is registered.
// Optional feature: define SPRITE_COLLISION_EN to add the collision pulse and per-frame collision counter.
module sprite_scheduler #(
    parameter int ELEMENT = 5,
    parameter int NREQ    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    active,
    input  logic                    frame_start,
    input  logic [NREQ-1:0]         req_en,
    input  logic [NREQ*ELEMENT-1:0] req_elem,
    input  logic [NREQ*10-1:0]      req_addr,
    output logic                    ready,
    output logic [ELEMENT-1:0]      element,
    output logic [9:0]              address,
    output logic [NREQ-1:0]         grant
`ifdef SPRITE_COLLISION_EN
    ,
    output logic                    collision,
    output logic [15:0]             collision_count
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, BLANK} state_t;

    state_t state_reg, state_next;

    logic               active_reg;
    logic               frame_start_reg;
    logic [NREQ-1:0]    req_en_reg;
    logic [ELEMENT-1:0] elem_reg [NREQ];
    logic [9:0]         addr_reg [NREQ];

    logic               grant_valid;
    logic [NREQ-1:0]    grant_oh;
    logic [ELEMENT-1:0] elem_sel;
    logic [9:0]         addr_sel;

    // Input sample stage: the FSM and arbiter only ever see registered pixel inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
            req_en_reg      <= '0;
        end else begin
            active_reg      <= active;
            frame_start_reg <= frame_start;
            req_en_reg      <= req_en;
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                elem_reg[gi] <= '0;
                addr_reg[gi] <= '0;
            end else begin
                elem_reg[gi] <= req_elem[gi*ELEMENT +: ELEMENT];
                addr_reg[gi] <= req_addr[gi*10 +: 10];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A frame restart overrides the current state from anywhere, including IDLE.
    always_comb begin
        state_next = state_reg;
        if (frame_start_reg) begin
            state_next = active_reg ? RUN : BLANK;
        end else begin
            case (state_reg)
                RUN:     if (!active_reg) state_next = BLANK;
                BLANK:   if (active_reg)  state_next = RUN;
                default: state_next = state_reg;
            endcase
        end
    end

    // Granting on the next state makes the same-cycle active value decide the pixel.
    always_comb begin
        grant_valid = (state_next == RUN) && (|req_en_reg);
        grant_oh    = req_en_reg & (~req_en_reg + NREQ'(1));
        elem_sel    = '0;
        addr_sel    = '0;
        for (int i = 0; i < NREQ; i++) begin
            elem_sel = elem_sel | (elem_reg[i] & {ELEMENT{grant_oh[i]}});
            addr_sel = addr_sel | (addr_reg[i] & {10{grant_oh[i]}});
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready   <= 1'b0;
            grant   <= '0;
            element <= '0;
            address <= '0;
        end else begin
            ready <= grant_valid;
            grant <= grant_valid ? grant_oh : '0;
            if (grant_valid) begin
                element <= elem_sel;
                address <= addr_sel;
            end
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic        multi_hit;
    logic        collision_next;
    logic [15:0] count_next;

    // Any set bit besides the winner means at least two sprites overlap this pixel.
    always_comb begin
        multi_hit      = |(req_en_reg & ~grant_oh);
        collision_next = grant_valid && multi_hit;
        count_next     = collision_count;
        if (frame_start_reg) begin
            count_next = collision_next ? 16'd1 : 16'd0;
        end else if (collision_next && (collision_count != 16'hFFFF)) begin
            count_next = collision_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            collision       <= 1'b0;
            collision_count <= '0;
        end else begin
            collision       <= collision_next;
            collision_count <= count_next;
        end
    end
`endif

endmodule

// File: tb/tb_sprite_scheduler.sv
// Testbench for sprite_scheduler: table-driven vectors checked through a latency-aware scoreboard queue.
module tb_sprite_scheduler;

    localparam logic [19:0] E  = {5'd1, 5'd7, 5'd5, 5'd9};              // e0=9  e1=5   e2=7   e3=1
    localparam logic [39:0] A  = {10'd400, 10'd300, 10'd37, 10'd12};    // a0=12 a1=37  a2=300 a3=400
    localparam logic [19:0] E2 = {5'd20, 5'd21, 5'd22, 5'd23};          // e0=23 e1=22  e2=21  e3=20
    localparam logic [39:0] A2 = {10'd500, 10'd600, 10'd700, 10'd800}; // a0=800 a1=700 a2=600 a3=500

    typedef struct {
        logic        fs;
        logic        act;
        logic [3:0]  en;
        logic [19:0] el;
        logic [39:0] ad;
        logic        rdy;
        logic [3:0]  g;
        logic [4:0]  e;
        logic [9:0]  a;
        logic        col;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        int   due;
        int   tag;
        vec_t v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        active = 1'b0;
    logic        frame_start = 1'b0;
    logic [3:0]  req_en = '0;
    logic [19:0] req_elem = '0;
    logic [39:0] req_addr = '0;
    logic        ready;
    logic [4:0]  element;
    logic [9:0]  address;
    logic [3:0]  grant;
`ifdef SPRITE_COLLISION_EN
    logic        collision;
    logic [15:0] collision_count;
`endif

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb[$];
    vec_t tbl[14];

    sprite_scheduler #(.ELEMENT(5), .NREQ(4)) dut (
        .clk(clk), .reset(reset), .active(active), .frame_start(frame_start),
        .req_en(req_en), .req_elem(req_elem), .req_addr(req_addr),
        .ready(ready), .element(element), .address(address), .grant(grant)
`ifdef SPRITE_COLLISION_EN
        , .collision(collision), .collision_count(collision_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Drive one pixel; its result is due two edges later (input stage + output stage).
    task automatic step(input int tag, input vec_t v);
        exp_t x;
        frame_start = v.fs;
        active      = v.act;
        req_en      = v.en;
        req_elem    = v.el;
        req_addr    = v.ad;
        x.due = cyc + 2;
        x.tag = tag;
        x.v   = v;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            exp_t x;
            x = sb.pop_front();
            chk($sformatf("v%0d.ready", x.tag), 64'(ready), 64'(x.v.rdy));
            chk($sformatf("v%0d.grant", x.tag), 64'(grant), 64'(x.v.g));
            chk($sformatf("v%0d.element", x.tag), 64'(element), 64'(x.v.e));
            chk($sformatf("v%0d.address", x.tag), 64'(address), 64'(x.v.a));
`ifdef SPRITE_COLLISION_EN
            chk($sformatf("v%0d.collision", x.tag), 64'(collision), 64'(x.v.col));
            chk($sformatf("v%0d.count", x.tag), 64'(collision_count), 64'(x.v.cnt));
`endif
        end
    end

    initial begin
        //            fs    act   en     el  ad  rdy   g      e      a        col   cnt
        tbl[0]  = '{1'b0, 1'b1, 4'hF, E,  A,  1'b0, 4'h0, 5'd0,  10'd0,   1'b0, 16'd0};
        tbl[1]  = '{1'b1, 1'b1, 4'h2, E,  A,  1'b1, 4'h2, 5'd5,  10'd37,  1'b0, 16'd0};
        tbl[2]  = '{1'b0, 1'b1, 4'hA, E,  A,  1'b1, 4'h2, 5'd5,  10'd37,  1'b1, 16'd1};
        tbl[3]  = '{1'b0, 1'b1, 4'h8, E,  A,  1'b1, 4'h8, 5'd1,  10'd400, 1'b0, 16'd1};
        tbl[4]  = '{1'b0, 1'b1, 4'h0, E,  A,  1'b0, 4'h0, 5'd1,  10'd400, 1'b0, 16'd1};
        tbl[5]  = '{1'b0, 1'b1, 4'h5, E,  A,  1'b1, 4'h1, 5'd9,  10'd12,  1'b1, 16'd2};
        tbl[6]  = '{1'b0, 1'b0, 4'h1, E,  A,  1'b0, 4'h0, 5'd9,  10'd12,  1'b0, 16'd2};
        tbl[7]  = '{1'b0, 1'b0, 4'hF, E,  A,  1'b0, 4'h0, 5'd9,  10'd12,  1'b0, 16'd2};
        tbl[8]  = '{1'b0, 1'b1, 4'h1, E2, A2, 1'b1, 4'h1, 5'd23, 10'd800, 1'b0, 16'd2};
        tbl[9]  = '{1'b0, 1'b1, 4'h4, E2, A2, 1'b1, 4'h4, 5'd21, 10'd600, 1'b0, 16'd2};
        tbl[10] = '{1'b1, 1'b0, 4'hF, E,  A,  1'b0, 4'h0, 5'd21, 10'd600, 1'b0, 16'd0};
        tbl[11] = '{1'b0, 1'b0, 4'h0, E,  A,  1'b0, 4'h0, 5'd21, 10'd600, 1'b0, 16'd0};
        tbl[12] = '{1'b1, 1'b1, 4'hC, E,  A,  1'b1, 4'h4, 5'd7,  10'd300, 1'b1, 16'd1};
        tbl[13] = '{1'b0, 1'b1, 4'h0, E,  A,  1'b0, 4'h0, 5'd7,  10'd300, 1'b0, 16'd1};

        // Asynchronous reset: outputs must clear without a clock edge.
        #2 reset = 1'b0;
        #1;
        chk("rst.ready", 64'(ready), 64'd0);
        chk("rst.grant", 64'(grant), 64'd0);
        chk("rst.element", 64'(element), 64'd0);
        chk("rst.address", 64'(address), 64'd0);
        #20 reset = 1'b1;
        @(posedge clk);
        #1;

        // No frame_start yet: requests with active high must never be granted.
        for (int i = 0; i < 100; i++)
            step(100 + i, '{1'b0, 1'b1, 4'hF, E, A, 1'b0, 4'h0, 5'd0, 10'd0, 1'b0, 16'd0});

        for (int i = 0; i < 14; i++)
            step(i, tbl[i]);
        drain();

`ifdef SPRITE_COLLISION_EN
        // Saturating collision counter, then cleared by a collision-free frame_start.
        @(posedge clk);
        #1;
        frame_start = 1'b1; active = 1'b1; req_en = 4'h3;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        chk("sat.count", 64'(collision_count), 64'hFFFF);
        chk("sat.collision", 64'(collision), 64'd1);
        @(posedge clk);
        #1;
        frame_start = 1'b1; req_en = 4'h1;
        @(posedge clk);
        #1;
        frame_start = 1'b0; req_en = 4'h0;
        @(posedge clk);
        @(negedge clk);
        chk("clr.count", 64'(collision_count), 64'd0);
        @(posedge clk);
        #1;
`endif

        // Reset asserted between edges while a grant is showing.
        step(200, '{1'b1, 1'b1, 4'h1, E, A, 1'b1, 4'h1, 5'd9, 10'd12, 1'b0, 16'd0});
        drain();
        chk("pre_rst.ready", 64'(ready), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst.ready", 64'(ready), 64'd0);
        chk("arst.grant", 64'(grant), 64'd0);
        chk("arst.element", 64'(element), 64'd0);
        chk("arst.address", 64'(address), 64'd0);
`ifdef SPRITE_COLLISION_EN
        chk("arst.count", 64'(collision_count), 64'd0);
`endif
        @(posedge clk);
        #3 reset = 1'b1;
        for (int i = 0; i < 5; i++)
            step(300 + i, '{1'b0, 1'b1, 4'hF, E, A, 1'b0, 4'h0, 5'd0, 10'd0, 1'b0, 16'd0});
        step(310, '{1'b1, 1'b1, 4'h2, E, A, 1'b1, 4'h2, 5'd5, 10'd37, 1'b0, 16'd0});
        step(311, '{1'b0, 1'b0, 4'h0, E, A, 1'b0, 4'h0, 5'd5, 10'd37, 1'b0, 16'd0});
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
